// File: rtl/mini_alu.sv
// HD44780 4-bit write-only LCD driver: power-on init, display setup, clear,
// then prints "HOLA MUNDO" on line 1 and goes quiet until the next reset.
module mini_alu #(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_NIB     = 50,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EN      = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [3:0] oLCD,
    output logic       oReadWrite,
    output logic       oRegisterSelect,
    output logic       oEnable
);

    localparam int CW = 20;

    typedef enum logic [2:0] {
        POWERON_WAIT,
        INIT,
        CONFIG,
        WRITE_CHARS,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ENABLE,
        PH_WAIT
    } phase_t;

    state_t         r_state, w_state_nx;
    phase_t         r_ph, w_ph_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic [2:0]     r_step, w_step_nx;
    logic           r_lower, w_lower_nx;
    logic [3:0]     r_idx, w_idx_nx;
    logic           r_started;
    logic [3:0]     r_lcd;
    logic           r_rs;
    logic           r_en;
    logic           w_active_nx;

    function automatic logic [7:0] cfg_byte(input logic [2:0] s);
        case (s)
            3'd0:    return 8'h28;
            3'd1:    return 8'h06;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h01;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] str_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h48;
            4'd1:    return 8'h4F;
            4'd2:    return 8'h4C;
            4'd3:    return 8'h41;
            4'd4:    return 8'h20;
            4'd5:    return 8'h4D;
            4'd6:    return 8'h55;
            4'd7:    return 8'h4E;
            4'd8:    return 8'h44;
            4'd9:    return 8'h4F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nib_of(input state_t st, input logic [2:0] step,
                                          input logic lower, input logic [3:0] idx);
        logic [7:0] b;
        b = (st == CONFIG) ? cfg_byte(step) : str_byte(idx);
        case (st)
            INIT:                return (step == 3'd3) ? 4'h2 : 4'h3;
            CONFIG, WRITE_CHARS: return lower ? b[3:0] : b[7:4];
            default:             return 4'h0;
        endcase
    endfunction

    // Reload value (delay - 1) for the wait that follows the current nibble
    function automatic logic [CW-1:0] post_of(input state_t st, input logic [2:0] step,
                                              input logic lower);
        if (st == INIT) begin
            if (step == 3'd0) return CW'(T_INIT1 - 1);
            if (step == 3'd1) return CW'(T_INIT2 - 1);
            return CW'(T_CMD - 1);
        end
        if (!lower) return CW'(T_NIB - 1);
        if (st == CONFIG && cfg_byte(step) == 8'h01) return CW'(T_CLEAR - 1);
        return CW'(T_CMD - 1);
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_ph_nx    = r_ph;
        w_step_nx  = r_step;
        w_lower_nx = r_lower;
        w_idx_nx   = r_idx;
        w_cnt_nx   = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
        case (r_state)
            POWERON_WAIT: begin
                // First cycle after reset arms the counter; it covers the remaining T_POWERON-1
                if (!r_started) begin
                    w_cnt_nx = CW'(T_POWERON - 2);
                end else if (r_cnt == '0) begin
                    w_state_nx = INIT;
                    w_ph_nx    = PH_SETUP;
                    w_cnt_nx   = CW'(T_SETUP - 1);
                end
            end
            DONE: w_cnt_nx = '0;
            default: begin
                if (r_cnt == '0) begin
                    case (r_ph)
                        PH_SETUP: begin
                            w_ph_nx  = PH_ENABLE;
                            w_cnt_nx = CW'(T_EN - 1);
                        end
                        PH_ENABLE: begin
                            w_ph_nx  = PH_WAIT;
                            w_cnt_nx = post_of(r_state, r_step, r_lower);
                        end
                        default: begin
                            w_ph_nx  = PH_SETUP;
                            w_cnt_nx = CW'(T_SETUP - 1);
                            case (r_state)
                                INIT: begin
                                    if (r_step == 3'd3) begin
                                        w_state_nx = CONFIG;
                                        w_step_nx  = 3'd0;
                                    end else begin
                                        w_step_nx = r_step + 3'd1;
                                    end
                                end
                                CONFIG: begin
                                    w_lower_nx = !r_lower;
                                    if (r_lower) begin
                                        if (r_step == 3'd4) begin
                                            w_state_nx = WRITE_CHARS;
                                            w_step_nx  = 3'd0;
                                        end else begin
                                            w_step_nx = r_step + 3'd1;
                                        end
                                    end
                                end
                                default: begin
                                    w_lower_nx = !r_lower;
                                    if (r_lower) begin
                                        if (r_idx != 4'd10) w_idx_nx = r_idx + 4'd1;
                                        if (r_idx == 4'd9) w_state_nx = DONE;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    assign w_active_nx = (w_state_nx == INIT) || (w_state_nx == CONFIG) ||
                         (w_state_nx == WRITE_CHARS);

    // Outputs are registered from next-state so E and data switch glitch-free together
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= POWERON_WAIT;
            r_ph      <= PH_SETUP;
            r_cnt     <= '0;
            r_step    <= '0;
            r_lower   <= 1'b0;
            r_idx     <= '0;
            r_started <= 1'b0;
            r_lcd     <= '0;
            r_rs      <= 1'b0;
            r_en      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ph      <= w_ph_nx;
            r_cnt     <= w_cnt_nx;
            r_step    <= w_step_nx;
            r_lower   <= w_lower_nx;
            r_idx     <= w_idx_nx;
            r_started <= 1'b1;
            r_lcd     <= nib_of(w_state_nx, w_step_nx, w_lower_nx, w_idx_nx);
            r_rs      <= (w_state_nx == WRITE_CHARS);
            r_en      <= w_active_nx && (w_ph_nx == PH_ENABLE);
        end
    end

    assign oLCD            = r_lcd;
    assign oRegisterSelect = r_rs;
    assign oEnable         = r_en;
    assign oReadWrite      = 1'b0;

endmodule

// File: tb/tb_mini_alu.sv
// Bench for mini_alu with shortened timing: records every E pulse and checks
// data, RS, widths and gaps against a pulse list built from the LCD protocol.
module tb_mini_alu;

    localparam int T_POWERON = 3000;
    localparam int T_INIT1   = 800;
    localparam int T_INIT2   = 300;
    localparam int T_CMD     = 100;
    localparam int T_CLEAR   = 400;
    localparam int T_NIB     = 20;
    localparam int T_SETUP   = 2;
    localparam int T_EN      = 12;
    localparam int N_PULSES  = 34;
    localparam int IDLE_CYC  = 20000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] oLCD;
    logic       oReadWrite;
    logic       oRegisterSelect;
    logic       oEnable;

    mini_alu #(
        .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
        .T_CLEAR(T_CLEAR), .T_NIB(T_NIB), .T_SETUP(T_SETUP), .T_EN(T_EN)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .oLCD(oLCD),
        .oReadWrite(oReadWrite),
        .oRegisterSelect(oRegisterSelect),
        .oEnable(oEnable)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Pulse recorder
    int       n_pulses = 0;
    int       rise_c [256];
    int       fall_c [256];
    int       p_nib  [256];
    int       p_rs   [256];
    int       p_rw   [256];
    int       p_bad  [256];
    logic     en_q = 1'b0;

    always @(negedge Clock) begin
        if (Reset) begin
            en_q <= 1'b0;
        end else begin
            if (oEnable && !en_q && n_pulses < 255) begin
                rise_c[n_pulses] <= cyc;
                p_nib[n_pulses]  <= int'(oLCD);
                p_rs[n_pulses]   <= int'(oRegisterSelect);
                p_rw[n_pulses]   <= int'(oReadWrite);
                p_bad[n_pulses]  <= 0;
                n_pulses         <= n_pulses + 1;
            end
            if (!oEnable && en_q && n_pulses > 0) fall_c[n_pulses-1] <= cyc;
            if (oEnable && en_q && n_pulses > 0 &&
                (int'(oLCD) != p_nib[n_pulses-1] || int'(oRegisterSelect) != p_rs[n_pulses-1]))
                p_bad[n_pulses-1] <= 1;
            en_q <= oEnable;
        end
    end

    // Reference pulse list
    int e_nib[$];
    int e_rs[$];
    int e_post[$];

    task automatic push_byte(input int rs, input int b);
        e_nib.push_back(b >> 4);  e_rs.push_back(rs); e_post.push_back(T_NIB);
        e_nib.push_back(b & 15);  e_rs.push_back(rs);
        e_post.push_back((rs == 0 && b == 1) ? T_CLEAR : T_CMD);
    endtask

    task automatic build_model();
        string txt;
        int    cmds[5];
        txt  = "HOLA MUNDO";
        cmds = '{8'h28, 8'h06, 8'h0C, 8'h01, 8'h80};
        e_nib  = '{3, 3, 3, 2};
        e_rs   = '{0, 0, 0, 0};
        e_post = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
        foreach (cmds[i]) push_byte(0, cmds[i]);
        for (int i = 0; i < txt.len(); i++) push_byte(1, int'(txt[i]));
    endtask

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        int waited;
        waited = 0;
        while (n_pulses < target && waited < budget) begin
            @(negedge Clock);
            waited++;
        end
        chk({tag, "_timeout"}, (n_pulses >= target) ? 1 : 0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_lcd"}, int'(oLCD), 0);
        chk({tag, "_rs"},  int'(oRegisterSelect), 0);
        chk({tag, "_en"},  int'(oEnable), 0);
        chk({tag, "_rw"},  int'(oReadWrite), 0);
    endtask

    int t0;
    int base;

    initial begin
        build_model();

        // Reset state
        repeat ($urandom_range(2, 6)) @(negedge Clock);
        #1 chk_outputs_zero("reset");

        // Full power-on sequence
        @(negedge Clock);
        Reset = 1'b0;
        t0    = cyc;
        base  = n_pulses;
        wait_pulses("run", base + N_PULSES, 12000);
        repeat (T_EN + 4) @(negedge Clock);
        chk_rng("first_rise", rise_c[base] - t0, T_POWERON, T_POWERON + T_SETUP + 2);
        for (int k = 0; k < N_PULSES; k++) begin
            chk($sformatf("nib[%0d]", k),    p_nib[base+k], e_nib[k]);
            chk($sformatf("rs[%0d]", k),     p_rs[base+k],  e_rs[k]);
            chk($sformatf("rw[%0d]", k),     p_rw[base+k],  0);
            chk($sformatf("width[%0d]", k),  fall_c[base+k] - rise_c[base+k], T_EN);
            chk($sformatf("stable[%0d]", k), p_bad[base+k], 0);
            if (k < N_PULSES - 1)
                chk_rng($sformatf("gap[%0d]", k), rise_c[base+k+1] - fall_c[base+k],
                        e_post[k], e_post[k] + T_SETUP + 1);
        end

        // Quiet after the string
        repeat (IDLE_CYC) @(negedge Clock);
        chk("idle_quiet", n_pulses - base, N_PULSES);
        chk_outputs_zero("done");

        // Restart, then reset in the middle of the 0x28 byte
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        base  = n_pulses;
        wait_pulses("rerun", base + 5, 6000);
        repeat ($urandom_range(0, T_EN + T_NIB)) @(negedge Clock);
        Reset = 1'b1;
        #1 chk_outputs_zero("midreset");
        repeat ($urandom_range(1, 4)) @(negedge Clock);
        Reset = 1'b0;
        t0    = cyc;
        base  = n_pulses;
        wait_pulses("after_mid", base + 1, T_POWERON + 200);
        repeat (T_EN + 4) @(negedge Clock);
        chk_rng("mid_first_rise", rise_c[base] - t0, T_POWERON, T_POWERON + T_SETUP + 2);
        chk("mid_first_nib", p_nib[base], 3);
        chk("mid_first_rs",  p_rs[base], 0);
        chk("mid_first_width", fall_c[base] - rise_c[base], T_EN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
